decode_pipe_ctrl: RTL and testbench
===================================

DECODE_PIPE_CTRL -- requirements
Module: decode_pipe_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- XLEN, 32, width of the PC and immediate datapath.
- ENABLE_M, 0, when 1, decode RV32M (funct7=1 on opcode 0110011); when 0, treat it as illegal.
- CNT_W, 16, width of the saturating stall counter.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, reset.
- in_valid, in, 1, fetch offers an instruction.
- in_ready, out, 1, the block accepts the instruction.
- in_instr, in, 32, instruction word.
- in_pc, in, XLEN, PC of in_instr.
- flush, in, 1, kill in-flight decode (branch taken / trap).
- ex_memread, in, 1, the instruction in EX is a load.
- ex_rd, in, 5, destination register of the instruction in EX.
- out_valid, out, 1, decoded bundle is valid.
- out_ready, in, 1, EX accepts the bundle.
- out_control, out, 10, {regwrite, alu_control[3:0], alusrc, memread, memwrite, branch, memtoreg}, i.e. bits 9,8:5,4,3,2,1,0.
- out_jump, out, 1, JAL/JALR.
- out_imm, out, XLEN, sign-extended immediate.
- out_rs1, out, 5, rs1 field.
- out_rs2, out, 5, rs2 field.
- out_rd, out, 5, rd field.
- out_pc, out, XLEN, PC of the decoded instruction.
- out_illegal, out, 1, undecodable instruction.
- stall_cnt, out, CNT_W, count of load-use bubbles.

REQ-003 The design SHALL use one clock (clk), with reset rst synchronous and active-high.

Function
REQ-004 Opcodes SHALL decode as: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; all other opcodes SHALL set out_illegal.

REQ-005 alu_control SHALL be:
- ADD 0000, SUB 0001, OR 0010, AND 0011, SLT 0100, SLL 0101, SRL 0110, SRA 0111, XOR 1000, SLTU 1001.
- Branches: BEQ/BNE 0001, BLT/BGE 0100, BLTU/BGEU 1001.
- LOAD/STORE/JAL/JALR/AUIPC/LUI SHALL use ADD; LUI SHALL also force rs1=0.
- ENABLE_M: MUL 1010, MULH* 1011, DIV* 1100, REM* 1101.

REQ-006 Control flags per class SHALL be:
- R: regwrite only.
- I-ALU: regwrite + alusrc.
- LOAD: regwrite, alusrc, memread, memtoreg.
- STORE: alusrc, memwrite.
- BRANCH: branch.
- JAL/JALR: regwrite, alusrc, branch, jump.
- LUI/AUIPC: regwrite, alusrc.
- Every unlisted flag SHALL be 0; no X outputs.

REQ-007 The following SHALL set out_illegal=1 with out_control=0 and out_jump=0:
- R-type funct7 not in {0, 32, 1 if ENABLE_M}.
- funct7=32 with funct3 not in {0, 5}.
- SLLI/SRLI with funct7≠0; SRAI with funct7≠32.
- Branch funct3 2 or 3.

REQ-008 The immediate SHALL be formatted per class (I, S, B, U, J) and sign-extended to XLEN; R-type immediate SHALL be 0.

REQ-009 Output stage SHALL be a single pipeline register:
- It loads when in_valid && in_ready.
- in_ready = !hazard && (!out_valid || out_ready).
- Latency from acceptance to out_valid SHALL be 1 cycle.

REQ-010 Output hold: while out_valid && !out_ready, all out_* SHALL hold stable.

REQ-011 Hazard SHALL be: ex_memread && ex_rd≠0 && ((ex_rd==rs1 && rs1 used) || (ex_rd==rs2 && rs2 used)).
- "Used" means: rs1 by all classes except LUI, AUIPC and JAL; rs2 by R, STORE and BRANCH only.

REQ-012 On hazard with in_valid, the block SHALL:
- drive in_ready=0;
- if the output stage can advance, load a bubble (out_valid=0) next cycle;
- increment stall_cnt by 1, saturating at all-ones.

REQ-013 flush SHALL have priority over every other event:
- The output register goes invalid next cycle.
- in_ready=1 that cycle and any accepted instruction is discarded.
- stall_cnt is not incremented.

REQ-014 Simultaneous out_ready and a new accept SHALL replace the bundle with no empty cycle, giving throughput of 1 instruction/cycle.

Reset
REQ-015 While rst=1 at a clk edge, the following SHALL be 0 on the next cycle:
- out_valid, out_control, out_jump, out_imm, out_rs1, out_rs2, out_rd, out_pc, out_illegal, stall_cnt.

REQ-016 During rst=1, in_ready SHALL be 0.

REQ-017 Reset mid-stall SHALL discard the held instruction.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD: 0x003100B3 accepted, out_ready=1 -> next cycle out_valid=1, out_control=10'b1_0000_00000, rd=1, rs1=2, rs2=3.
- SRAI vs illegal: SRAI x5,x6,3 (0x40335293) -> alu_control=0111, alusrc=1, imm=3; 0x80335293 -> out_illegal=1, out_control=0.
- Load-use: ex_memread=1, ex_rd=7, instr ADD x8,x7,x1 -> in_ready=0, bubble one cycle, stall_cnt=1; ex_memread=0 next cycle -> accepted.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> next instruction appears the following cycle.
- Flush: flush=1 while out_valid=1 and a BEQ is offered -> out_valid=0 next cycle, BEQ never appears, stall_cnt unchanged.
- Saturation and reset: CNT_W=2 with 5 consecutive hazards -> stall_cnt=3; rst=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pipe_ctrl.sv
// decode_pipe_ctrl: RV32I (optional RV32M) decode stage with a single output
// pipeline register, load-use hazard stall and a saturating bubble counter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_instr/in_pc are the offered word
//   flush               kills the output register and discards any accept
//   ex_memread, ex_rd   load in EX and its destination (load-use detection)
//   out_valid/out_ready EX handshake for the decoded bundle
//   out_control         {regwrite, alu_control[3:0], alusrc, memread,
//                        memwrite, branch, memtoreg}
//   out_jump, out_imm, out_rs1, out_rs2, out_rd, out_pc, out_illegal
//   stall_cnt           saturating count of load-use stall cycles
module decode_pipe_ctrl #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             flush,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [9:0]       out_control,
    output logic             out_jump,
    output logic [XLEN-1:0]  out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_MULH = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_REM  = 4'b1101;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    // Shared funct3 -> ALU op map for R-type and I-ALU; alt selects SUB/SRA.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    arith_op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    arith_op = ALU_SLL;
            3'd2:    arith_op = ALU_SLT;
            3'd3:    arith_op = ALU_SLTU;
            3'd4:    arith_op = ALU_XOR;
            3'd5:    arith_op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    logic            regwrite, alusrc, memread, memwrite, branch, memtoreg, jump, bad;
    logic [3:0]      alu;
    logic [31:0]     imm32;
    logic [9:0]      dec_control;
    logic            dec_jump;
    logic [XLEN-1:0] dec_imm;
    logic [4:0]      dec_rs1;

    always_comb begin
        regwrite = 1'b0;
        alusrc   = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        branch   = 1'b0;
        memtoreg = 1'b0;
        jump     = 1'b0;
        bad      = 1'b0;
        alu      = ALU_ADD;
        imm32    = '0;
        case (opcode)
            OP_R: begin
                regwrite = 1'b1;
                if (funct7 == 7'd0) begin
                    alu = arith_op(funct3, 1'b0);
                end else if (funct7 == 7'd32) begin
                    alu = arith_op(funct3, 1'b1);
                    bad = (funct3 != 3'd0) && (funct3 != 3'd5);
                end else if (funct7 == 7'd1 && ENABLE_M) begin
                    if (funct3 == 3'd0)      alu = ALU_MUL;
                    else if (funct3 < 3'd4)  alu = ALU_MULH;
                    else if (funct3 < 3'd6)  alu = ALU_DIV;
                    else                     alu = ALU_REM;
                end else begin
                    bad = 1'b1;
                end
            end
            OP_I: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                alu      = arith_op(funct3, 1'b0);
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
                // Shifts carry the shamt only; funct7 selects/validates the kind.
                if (funct3 == 3'd1) begin
                    imm32 = {27'd0, in_instr[24:20]};
                    bad   = (funct7 != 7'd0);
                end else if (funct3 == 3'd5) begin
                    imm32 = {27'd0, in_instr[24:20]};
                    if (funct7 == 7'd32)     alu = ALU_SRA;
                    else if (funct7 != 7'd0) bad = 1'b1;
                end
            end
            OP_LOAD: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                memread  = 1'b1;
                memtoreg = 1'b1;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                alusrc   = 1'b1;
                memwrite = 1'b1;
                imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                branch = 1'b1;
                imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
                case (funct3)
                    3'd0, 3'd1: alu = ALU_SUB;
                    3'd4, 3'd5: alu = ALU_SLT;
                    3'd6, 3'd7: alu = ALU_SLTU;
                    default:    bad = 1'b1;
                endcase
            end
            OP_JAL: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                branch   = 1'b1;
                jump     = 1'b1;
                imm32    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                branch   = 1'b1;
                jump     = 1'b1;
                imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LUI, OP_AUIPC: begin
                regwrite = 1'b1;
                alusrc   = 1'b1;
                imm32    = {in_instr[31:12], 12'd0};
            end
            default: bad = 1'b1;
        endcase
    end

    // Illegal words carry no control, no jump and a zero immediate.
    assign dec_control = bad ? 10'd0 :
                         {regwrite, alu, alusrc, memread, memwrite, branch, memtoreg};
    assign dec_jump    = jump && !bad;
    assign dec_imm     = bad ? '0 : XLEN'($signed(imm32));
    assign dec_rs1     = (opcode == OP_LUI) ? 5'd0 : rs1;

    // Register use is a property of the opcode class alone.
    logic use_rs1, use_rs2, hazard, can_adv, accept;

    assign use_rs1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JALR);
    assign use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign hazard  = ex_memread && (ex_rd != 5'd0) &&
                     (((ex_rd == rs1) && use_rs1) || ((ex_rd == rs2) && use_rs2));
    assign can_adv = !out_valid || out_ready;
    // flush opens the input so fetch can drain; the accepted word is dropped.
    assign in_ready = !rst && (flush || (!hazard && can_adv));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_control <= '0;
            out_jump    <= 1'b0;
            out_imm     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            stall_cnt   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (in_valid && hazard && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (accept) begin
                out_valid   <= 1'b1;
                out_control <= dec_control;
                out_jump    <= dec_jump;
                out_imm     <= dec_imm;
                out_rs1     <= dec_rs1;
                out_rs2     <= rs2;
                out_rd      <= rd;
                out_pc      <= in_pc;
                out_illegal <= bad;
            end else if (can_adv) begin
                // consumed with nothing behind it, or a load-use bubble
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Scoreboard bench for decode_pipe_ctrl. Two instances share all inputs:
// "m" (ENABLE_M=1, CNT_W=16) and "s" (ENABLE_M=0, CNT_W=2).
module tb_decode_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1, in_valid = 1'b0, flush = 1'b0, ex_memread = 1'b0, out_ready = 1'b0;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [4:0]  ex_rd = '0;

    logic        in_ready_m, out_valid_m, out_jump_m, out_illegal_m;
    logic [9:0]  out_control_m;
    logic [31:0] out_imm_m, out_pc_m;
    logic [4:0]  out_rs1_m, out_rs2_m, out_rd_m;
    logic [15:0] stall_cnt_m;

    logic        in_ready_s, out_valid_s, out_jump_s, out_illegal_s;
    logic [9:0]  out_control_s;
    logic [31:0] out_imm_s, out_pc_s;
    logic [4:0]  out_rs1_s, out_rs2_s, out_rd_s;
    logic [1:0]  stall_cnt_s;

    decode_pipe_ctrl #(.XLEN(32), .ENABLE_M(1'b1), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_control(out_control_m), .out_jump(out_jump_m), .out_imm(out_imm_m),
        .out_rs1(out_rs1_m), .out_rs2(out_rs2_m), .out_rd(out_rd_m), .out_pc(out_pc_m),
        .out_illegal(out_illegal_m), .stall_cnt(stall_cnt_m));

    decode_pipe_ctrl #(.XLEN(32), .ENABLE_M(1'b0), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_control(out_control_s), .out_jump(out_jump_s), .out_imm(out_imm_s),
        .out_rs1(out_rs1_s), .out_rs2(out_rs2_s), .out_rd(out_rd_s), .out_pc(out_pc_s),
        .out_illegal(out_illegal_s), .stall_cnt(stall_cnt_s));

    always #5 clk = ~clk;

    typedef logic [90:0] bundle_t;  // {ctl, jump, imm, rs1, rs2, rd, pc, illegal}
    typedef struct { bundle_t m; bundle_t s; } exp_t;

    exp_t q[$];
    bit   ov  = 1'b0;  // model: output register holds a valid bundle
    int   cnt = 0;     // model: unsaturated-at-16-bit stall count
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference decode written from the instruction-set tables.
    function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
        logic [3:0] arith[8] = '{4'd0, 4'd5, 4'd4, 4'd9, 4'd8, 4'd6, 4'd2, 4'd3};
        logic [3:0] mext[8]  = '{4'd10, 4'd11, 4'd11, 4'd11, 4'd12, 4'd12, 4'd13, 4'd13};
        logic [6:0] op = ins[6:0];
        logic [6:0] f7 = ins[31:25];
        int  f3 = int'(ins[14:12]);
        bit  rw = 0, src = 0, mr = 0, mw = 0, br = 0, m2r = 0, j = 0, ill = 0;
        logic [3:0]  alu = 4'd0;
        logic [31:0] imm = 0, i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [4:0]  r1 = ins[19:15];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = {ins[31:12], 12'd0};
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (op)
            7'h33: begin
                rw = 1;
                if (f7 == 0) alu = arith[f3];
                else if (f7 == 32 && f3 == 0) alu = 4'd1;
                else if (f7 == 32 && f3 == 5) alu = 4'd7;
                else if (f7 == 1 && en_m) alu = mext[f3];
                else ill = 1;
            end
            7'h13: begin
                rw = 1; src = 1; alu = arith[f3]; imm = i_imm;
                if (f3 == 1 || f3 == 5) begin
                    imm = 32'(ins[24:20]);
                    if (f3 == 5 && f7 == 32) alu = 4'd7;
                    else if (f7 != 0) ill = 1;
                end
            end
            7'h03: begin rw = 1; src = 1; mr = 1; m2r = 1; imm = i_imm; end
            7'h23: begin src = 1; mw = 1; imm = s_imm; end
            7'h63: begin
                br = 1; imm = b_imm;
                if (f3 == 2 || f3 == 3) ill = 1;
                else alu = (f3 < 2) ? 4'd1 : (f3 < 6) ? 4'd4 : 4'd9;
            end
            7'h6F: begin rw = 1; src = 1; br = 1; j = 1; imm = j_imm; end
            7'h67: begin rw = 1; src = 1; br = 1; j = 1; imm = i_imm; end
            7'h37: begin rw = 1; src = 1; imm = u_imm; r1 = 0; end
            7'h17: begin rw = 1; src = 1; imm = u_imm; end
            default: ill = 1;
        endcase
        if (ill) return {10'd0, 1'b0, 32'd0, r1, ins[24:20], ins[11:7], pc, 1'b1};
        return {rw, alu, src, mr, mw, br, m2r, j, imm, r1, ins[24:20], ins[11:7], pc, 1'b0};
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ins, input bit exm, input logic [4:0] exd);
        logic [6:0] op = ins[6:0];
        bit u1 = (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h23 || op == 7'h63 || op == 7'h67);
        bit u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
        return exm && exd != 0 && ((exd == ins[19:15] && u1) || (exd == ins[24:20] && u2));
    endfunction

    // One clock of stimulus; advances the model at the active edge.
    task automatic cyc(input bit r, input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit exm, input logic [4:0] exd, input bit ordy);
        bit hz, rdy;
        @(negedge clk);
        rst = r; in_valid = iv; in_instr = ins; in_pc = pc;
        flush = fl; ex_memread = exm; ex_rd = exd; out_ready = ordy;
        #1;
        hz  = ref_hazard(ins, exm, exd);
        rdy = !r && (fl || (!hz && (!ov || ordy)));
        chk("in_ready_m", in_ready_m, rdy);
        chk("in_ready_s", in_ready_s, rdy);
        @(posedge clk);
        if (r) begin
            ov = 0; q.delete(); cnt = 0;
        end else if (fl) begin
            ov = 0; q.delete();
        end else begin
            if (iv && hz && cnt < 65535) cnt++;
            if (iv && rdy) begin
                q.push_back('{m: ref_decode(ins, pc, 1'b1), s: ref_decode(ins, pc, 1'b0)});
                ov = 1;
            end else if (!ov || ordy) begin
                ov = 0;
            end
        end
    endtask

    // Monitor: compares presented bundles against the queue head every cycle
    // (which also checks stability under backpressure); pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("out_valid_m", out_valid_m, ov);
            chk("out_valid_s", out_valid_s, ov);
            chk("stall_cnt_m", stall_cnt_m, cnt);
            chk("stall_cnt_s", stall_cnt_s, (cnt > 3) ? 3 : cnt);
            if (ov) begin
                chk("queue_nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("bundle_m", {out_control_m, out_jump_m, out_imm_m, out_rs1_m, out_rs2_m,
                                     out_rd_m, out_pc_m, out_illegal_m}, q[0].m);
                    chk("bundle_s", {out_control_s, out_jump_s, out_imm_s, out_rs1_s, out_rs2_s,
                                     out_rd_s, out_pc_s, out_illegal_s}, q[0].s);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_valid", {out_valid_m, out_valid_s}, 0);
        chk("rst_bundle_m", {out_control_m, out_jump_m, out_imm_m, out_rs1_m, out_rs2_m,
                             out_rd_m, out_pc_m, out_illegal_m}, 0);
        chk("rst_bundle_s", {out_control_s, out_jump_s, out_imm_s, out_rs1_s, out_rs2_s,
                             out_rd_s, out_pc_s, out_illegal_s}, 0);
        chk("rst_cnt", {stall_cnt_m, stall_cnt_s}, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
        logic [31:0] w = $urandom;
        int k = $urandom_range(0, 9);
        int s = $urandom_range(0, 3);
        w[6:0]   = (k == 9) ? 7'($urandom) : ops[k];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        if (s == 0) w[31:25] = 7'd0;
        else if (s == 1) w[31:25] = 7'd32;
        else if (s == 2) w[31:25] = 7'd1;
        return w;
    endfunction

    initial begin
        // reset
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 32'h003100B3, 0, 0, 0, 0, 1);
        #1 chk_reset_state();

        // ADD x1,x2,x3
        cyc(0, 1, 32'h003100B3, 32'h100, 0, 0, 0, 1);
        #1;
        chk("add_valid", out_valid_m, 1);
        chk("add_ctrl", out_control_m, 10'b1_0000_00000);
        chk("add_regs", {out_rd_m, out_rs1_m, out_rs2_m}, {5'd1, 5'd2, 5'd3});

        // SRAI x5,x6,3 then the same with a bad funct7
        cyc(0, 1, 32'h40335293, 32'h104, 0, 0, 0, 1);
        #1;
        chk("srai_ctrl", out_control_m, 10'b1_0111_1_0000);
        chk("srai_imm", out_imm_m, 3);
        cyc(0, 1, 32'h80335293, 32'h108, 0, 0, 0, 1);
        #1;
        chk("srai_bad_ill", out_illegal_m, 1);
        chk("srai_bad_ctl", out_control_m, 0);

        // load-use: ADD x8,x7,x1 behind a load to x7
        cyc(0, 1, 32'h00138433, 32'h10C, 0, 1, 7, 1);
        #1;
        chk("lu_bubble", out_valid_m, 0);
        chk("lu_cnt", stall_cnt_m, 1);
        cyc(0, 1, 32'h00138433, 32'h10C, 0, 0, 0, 1);
        #1 chk("lu_accept_rd", {out_valid_m, out_rd_m}, {1'b1, 5'd8});

        // backpressure: ADDI in output, ANDI waits three cycles
        cyc(0, 1, 32'h00508493, 32'h110, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h0FF17513, 32'h114, 0, 0, 0, 0);
        #1 chk("bp_hold_rd", out_rd_m, 9);
        cyc(0, 1, 32'h0FF17513, 32'h114, 0, 0, 0, 1);
        #1 chk("bp_next_rd", {out_valid_m, out_rd_m}, {1'b1, 5'd10});

        // flush with a BEQ offered while the output is occupied
        cyc(0, 1, 32'h00208463, 32'h118, 1, 0, 0, 0);
        #1;
        chk("flush_valid", out_valid_m, 0);
        chk("flush_cnt", stall_cnt_m, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // saturation on the narrow counter, then reset
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 32'h00138433, 32'h120, 0, 1, 7, 1);
        #1;
        chk("sat_s", stall_cnt_s, 3);
        chk("sat_m", stall_cnt_m, 5);
        cyc(1, 1, 32'h00138433, 32'h120, 0, 1, 7, 1);
        #1 chk_reset_state();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, rand_instr(),
                $urandom & 32'hFFFF_FFFC, $urandom_range(0, 14) == 0,
                $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
